// File: rtl/matrix_pkg.sv
// Shared types for the matrix output path: element width, element type and
// the row accumulator state encoding.
package matrix_pkg;
  localparam int DATA_W = 16;
  typedef logic [DATA_W-1:0] elem_t;
  typedef enum logic {ACCUM, DONE} acc_state_t;
endpackage

// File: rtl/sixtnBitAdder.sv
// 16-bit ripple-carry adder/subtractor: sum = a + (b ^ {16{subtract}}) + (Cin0 ^ subtract).
// C15 is the carry out of bit 15.
module sixtnBitAdder
  import matrix_pkg::*;
(
  input  elem_t a,
  input  elem_t b,
  input  logic  Cin0,
  input  logic  subtract,
  output elem_t sum,
  output logic  C15
);
  elem_t             bx;
  logic [DATA_W:0]   c;

  always_comb begin
    bx   = b ^ {DATA_W{subtract}};
    c    = '0;
    sum  = '0;
    c[0] = Cin0 ^ subtract;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    C15 = c[DATA_W];
  end
endmodule

// File: rtl/row_accumulator_16.sv
// Accumulates LEN 16-bit elements (add or subtract each) into a row sum and
// presents it with a sticky carry/borrow flag over a valid/ready handshake.
module row_accumulator_16
  import matrix_pkg::*;
#(
  parameter int unsigned LEN = 4,
  parameter int unsigned CW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf
);
  acc_state_t    state, state_n;
  elem_t         acc, acc_n, add_sum;
  logic [CW-1:0] cnt, cnt_n;
  logic          ovf, ovf_n;
  logic          c15, step_ovf;

  sixtnBitAdder u_adder (
    .a        (acc),
    .b        (in_data),
    .Cin0     (1'b0),
    .subtract (in_sub),
    .sum      (add_sum),
    .C15      (c15)
  );

  // Carry-out on add; missing carry-out means a borrow on subtract.
  assign step_ovf = in_sub ? ~c15 : c15;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    if (flush) begin
      state_n = ACCUM;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (in_valid) begin
            acc_n = add_sum;
            ovf_n = ovf | step_ovf;
            if (cnt == CW'(LEN - 1)) begin
              cnt_n   = '0;
              state_n = DONE;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            acc_n   = '0;
            ovf_n   = 1'b0;
            state_n = ACCUM;
          end
        end
        default: state_n = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end
endmodule

// File: tb/tb_row_accumulator_16.sv
// Scoreboard bench for row_accumulator_16 (LEN=4): expected rows are queued by
// the stimulus process and checked by a monitor on each output handshake.
module tb_row_accumulator_16;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_sub, out_valid, out_ready, out_ovf;
  logic [15:0] in_data, out_sum;

  int ntests = 0;
  int nfail  = 0;
  logic [16:0] expq[$];

  row_accumulator_16 #(.LEN(4), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake happens on the next posedge when out_valid & out_ready
  // and neither flush nor reset overrides it.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready && !flush && !reset) begin
        if (expq.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexpected_result: got sum=0x%0h ovf=%0b expected none", out_sum, out_ovf);
        end else begin
          e = expq.pop_front();
          chk("row_sum", {16'h0, out_sum}, {16'h0, e[15:0]});
          chk("row_ovf", {31'h0, out_ovf}, {31'h0, e[16]});
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic s);
    int k = 0;
    in_data  = d;
    in_sub   = s;
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (expq.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    #2;
    chk(name, expq.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready",  {31'h0, in_ready},  32'd1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_sum",   {16'h0, out_sum},   32'd0);
    chk("rst_out_ovf",   {31'h0, out_ovf},   32'd0);

    // Row 1: 50+13+7+30 = 100, one-cycle out_valid right after 4th accept.
    expq.push_back({1'b0, 16'd100});
    send(16'd50, 1'b0); send(16'd13, 1'b0); send(16'd7, 1'b0); send(16'd30, 1'b0);
    chk("lat_out_valid", {31'h0, out_valid}, 32'd1);
    chk("lat_in_ready",  {31'h0, in_ready},  32'd0);
    @(negedge clk);
    chk("pulse_out_valid", {31'h0, out_valid}, 32'd0);
    chk("after_in_ready",  {31'h0, in_ready},  32'd1);
    drain("drain_row1");

    // +50 -13 -40 +3: 37-40 borrows to 0xFFFD, final sum 0, flag sticky.
    expq.push_back({1'b1, 16'h0000});
    send(16'd50, 1'b0); send(16'd13, 1'b1); send(16'd40, 1'b1); send(16'd3, 1'b0);
    drain("drain_row2");

    // Wrap-around carry, then a clean row proves the flag is cleared.
    expq.push_back({1'b1, 16'h0001});
    send(16'hFFFF, 1'b0); send(16'h0002, 1'b0); send(16'h0000, 1'b0); send(16'h0000, 1'b0);
    expq.push_back({1'b0, 16'd4});
    send(16'd1, 1'b0); send(16'd1, 1'b0); send(16'd1, 1'b0); send(16'd1, 1'b0);
    drain("drain_row4");

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    expq.push_back({1'b0, 16'd10});
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data  = 16'h1234;
      in_sub   = 1'b0;
      #1;
      chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'h0, in_ready},  32'd0);
      chk("bp_out_sum",   {16'h0, out_sum},   32'd10);
      chk("bp_out_ovf",   {31'h0, out_ovf},   32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_in_ready", {31'h0, in_ready}, 32'd1);
    drain("drain_bp");

    // Flush mid-row (element presented with flush is dropped too).
    send(16'd9, 1'b0); send(16'd9, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd5; in_sub = 1'b0;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    expq.push_back({1'b0, 16'd10});
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b0);
    drain("drain_flush_row");

    // Flush discards a pending result even with out_ready=1.
    out_ready = 1'b0;
    send(16'd7, 1'b0); send(16'd7, 1'b0); send(16'd7, 1'b0); send(16'd7, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_out_valid", {31'h0, out_valid}, 32'd0);
    chk("flush_done_out_sum",   {16'h0, out_sum},   32'd0);

    // Reset while a result is pending.
    out_ready = 1'b0;
    send(16'hFFFF, 1'b0); send(16'd5, 1'b0); send(16'd1, 1'b0); send(16'd1, 1'b0);
    chk("pre_rst_out_valid", {31'h0, out_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("done_rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("done_rst_in_ready",  {31'h0, in_ready},  32'd1);
    chk("done_rst_out_sum",   {16'h0, out_sum},   32'd0);
    chk("done_rst_out_ovf",   {31'h0, out_ovf},   32'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", expq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
